// File: rtl/sdram_axi_rd_responder_pkg.sv
// Shared encodings for the SDRAM AXI read responder: FSM states, AXI response
// and burst codes, and the beat-count helper.
package sdram_axi_rd_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_STREAM,
        ST_ERR
    } state_t;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR   = 2'b01;

    // ARLEN=255 gives 256 beats, so the count needs nine bits.
    function automatic logic [8:0] beats_of(input logic [7:0] arlen);
        return {1'b0, arlen} + 9'd1;
    endfunction

endpackage

// File: rtl/sdram_axi_rd_responder_skid.sv
// Two-entry skid FIFO between the read-FIFO pop pipeline and the R channel;
// the head entry drives RDATA.
module sdram_axi_rd_skid #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
        end
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/sdram_axi_rd_responder.sv
// AXI4 read responder: one AR request becomes one SDRAM read burst, which is
// streamed back on R from the read FIFO once the whole burst has landed.
module sdram_axi_rd_responder
    import sdram_axi_rd_responder_pkg::*;
#(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 23,
    parameter int C_S_AXI_DATA_WIDTH = 16,
    parameter int MAX_BURST          = 16
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [7:0]                    S_AXI_ARLEN,
    input  logic [2:0]                    S_AXI_ARSIZE,
    input  logic [1:0]                    S_AXI_ARBURST,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RLAST,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    input  logic                          init_end,
    output logic                          sdram_rd_req,
    output logic [C_S_AXI_ADDR_WIDTH-1:0] sdram_rd_b_addr,
    output logic [C_S_AXI_ADDR_WIDTH-1:0] sdram_rd_e_addr,
    output logic [7:0]                    rd_burst_len,
    output logic                          rd_fifo_rd_req,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] rd_fifo_rd_data,
    input  logic [9:0]                    rd_fifo_num,
    output logic                          busy
);

    localparam logic [2:0] AXSIZE = 3'($clog2(C_S_AXI_DATA_WIDTH / 8));

    state_t                        state_q, state_d;
    logic                          arready_q, arready_d;
    logic [C_S_AXI_ID_WIDTH-1:0]   rid_q, rid_d;
    logic [8:0]                    beats_q, beats_d;
    logic                          rd_req_q, rd_req_d;
    logic [C_S_AXI_ADDR_WIDTH-1:0] b_addr_q, b_addr_d;
    logic [C_S_AXI_ADDR_WIDTH-1:0] e_addr_q, e_addr_d;
    logic [7:0]                    len_q, len_d;
    logic [8:0]                    popped_q, popped_d;
    logic [8:0]                    sent_q, sent_d;
    logic                          inflight_q, inflight_d;

    logic [8:0]                    ar_beats;
    logic                          ar_bad;
    logic                          ar_hs;
    logic                          r_hs;
    logic                          last_beat;
    logic                          skid_pop;
    logic                          fifo_pop;
    logic [2:0]                    occupancy;
    logic [1:0]                    skid_count;
    logic [C_S_AXI_DATA_WIDTH-1:0] skid_head;

    sdram_axi_rd_skid #(
        .DATA_W (C_S_AXI_DATA_WIDTH)
    ) u_skid (
        .clk       (S_AXI_ACLK),
        .rst_n     (S_AXI_ARESETN),
        .push      (inflight_q),
        .push_data (rd_fifo_rd_data),
        .pop       (skid_pop),
        .head_data (skid_head),
        .count     (skid_count)
    );

    assign ar_beats  = beats_of(S_AXI_ARLEN);
    assign ar_bad    = (S_AXI_ARBURST != BURST_INCR) || (S_AXI_ARSIZE != AXSIZE)
                       || (ar_beats > 9'(MAX_BURST));
    assign ar_hs     = (state_q == ST_IDLE) && arready_q && S_AXI_ARVALID;
    assign r_hs      = S_AXI_RVALID && S_AXI_RREADY;
    assign last_beat = (sent_q == beats_q - 9'd1);
    assign skid_pop  = (state_q == ST_STREAM) && r_hs;

    // Words held plus the one in flight, less the one leaving this cycle;
    // popping only below two keeps the skid buffer from ever overflowing.
    assign occupancy = {1'b0, skid_count} + {2'b0, inflight_q} - {2'b0, skid_pop};
    assign fifo_pop  = (state_q == ST_STREAM) && (popped_q < beats_q) && (occupancy < 3'd2);

    always_comb begin
        state_d    = state_q;
        arready_d  = arready_q;
        rid_d      = rid_q;
        beats_d    = beats_q;
        rd_req_d   = 1'b0;
        b_addr_d   = b_addr_q;
        e_addr_d   = e_addr_q;
        len_d      = len_q;
        popped_d   = popped_q;
        sent_d     = sent_q;
        inflight_d = fifo_pop;
        unique case (state_q)
            ST_IDLE: begin
                arready_d = init_end;
                if (ar_hs) begin
                    arready_d = 1'b0;
                    rid_d     = S_AXI_ARID;
                    beats_d   = ar_beats;
                    popped_d  = 9'd0;
                    sent_d    = 9'd0;
                    if (ar_bad) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d  = ST_REQ;
                        rd_req_d = 1'b1;
                        b_addr_d = S_AXI_ARADDR;
                        e_addr_d = S_AXI_ARADDR + C_S_AXI_ADDR_WIDTH'(ar_beats);
                        len_d    = ar_beats[7:0];
                    end
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (rd_fifo_num >= {1'b0, beats_q}) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM, ST_ERR: begin
                if ((state_q == ST_STREAM) && fifo_pop) begin
                    popped_d = popped_q + 9'd1;
                end
                if (r_hs) begin
                    sent_d = sent_q + 9'd1;
                    if (last_beat) begin
                        state_d   = ST_IDLE;
                        arready_d = init_end;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q    <= ST_IDLE;
            arready_q  <= 1'b0;
            rid_q      <= '0;
            beats_q    <= 9'd0;
            rd_req_q   <= 1'b0;
            b_addr_q   <= '0;
            e_addr_q   <= '0;
            len_q      <= 8'd0;
            popped_q   <= 9'd0;
            sent_q     <= 9'd0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            arready_q  <= arready_d;
            rid_q      <= rid_d;
            beats_q    <= beats_d;
            rd_req_q   <= rd_req_d;
            b_addr_q   <= b_addr_d;
            e_addr_q   <= e_addr_d;
            len_q      <= len_d;
            popped_q   <= popped_d;
            sent_q     <= sent_d;
            inflight_q <= inflight_d;
        end
    end

    assign S_AXI_ARREADY   = arready_q;
    assign S_AXI_RID       = rid_q;
    assign S_AXI_RVALID    = (state_q == ST_ERR) || ((state_q == ST_STREAM) && (skid_count != 2'd0));
    assign S_AXI_RDATA     = (state_q == ST_STREAM) ? skid_head : '0;
    assign S_AXI_RRESP     = (state_q == ST_ERR) ? RRESP_SLVERR : RRESP_OKAY;
    assign S_AXI_RLAST     = S_AXI_RVALID && last_beat;
    assign sdram_rd_req    = rd_req_q;
    assign sdram_rd_b_addr = b_addr_q;
    assign sdram_rd_e_addr = e_addr_q;
    assign rd_burst_len    = len_q;
    assign rd_fifo_rd_req  = fifo_pop;
    assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdram_axi_rd_responder.sv
// Directed bench for sdram_axi_rd_responder: a read-FIFO model fills on each
// SDRAM burst request, and a scoreboard of expected R beats is checked on output.
module tb_sdram_axi_rd_responder;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  resp;
        logic        last;
        logic        id;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arid = 1'b0;
    logic [22:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = 3'd1;
    logic [1:0]  arburst = 2'b01;
    logic        arvalid = 1'b0;
    logic        arready;
    logic        rid;
    logic [15:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b1;
    logic        init_end = 1'b1;
    logic        sdram_rd_req;
    logic [22:0] sdram_rd_b_addr;
    logic [22:0] sdram_rd_e_addr;
    logic [7:0]  rd_burst_len;
    logic        rd_fifo_rd_req;
    logic [15:0] rd_fifo_rd_data = '0;
    logic [9:0]  rd_fifo_num = '0;
    logic        busy;

    always #5 clk = ~clk;

    sdram_axi_rd_responder dut (
        .S_AXI_ACLK      (clk),
        .S_AXI_ARESETN   (rst_n),
        .S_AXI_ARID      (arid),
        .S_AXI_ARADDR    (araddr),
        .S_AXI_ARLEN     (arlen),
        .S_AXI_ARSIZE    (arsize),
        .S_AXI_ARBURST   (arburst),
        .S_AXI_ARVALID   (arvalid),
        .S_AXI_ARREADY   (arready),
        .S_AXI_RID       (rid),
        .S_AXI_RDATA     (rdata),
        .S_AXI_RRESP     (rresp),
        .S_AXI_RLAST     (rlast),
        .S_AXI_RVALID    (rvalid),
        .S_AXI_RREADY    (rready),
        .init_end        (init_end),
        .sdram_rd_req    (sdram_rd_req),
        .sdram_rd_b_addr (sdram_rd_b_addr),
        .sdram_rd_e_addr (sdram_rd_e_addr),
        .rd_burst_len    (rd_burst_len),
        .rd_fifo_rd_req  (rd_fifo_rd_req),
        .rd_fifo_rd_data (rd_fifo_rd_data),
        .rd_fifo_num     (rd_fifo_num),
        .busy            (busy)
    );

    beat_t       sb[$];
    logic [15:0] fifo_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          pops = 0;
    int          rd_req_cnt = 0;
    int          rd_req_cycle = 0;
    int          ar_cycle = 0;
    int          burst_hs = 0;
    int          burst_pops = 0;
    int          max_ahead = 0;
    int          first_hs_cyc = 0;
    int          last_hs_cyc = 0;
    logic [22:0] last_b = '0;
    logic [22:0] last_e = '0;
    logic [7:0]  last_len = '0;
    logic        stalled = 1'b0;
    beat_t       held;
    beat_t       mon_obs;
    beat_t       mon_exp;
    logic        mon_do_pop;
    logic [15:0] mon_nxt;

    function automatic logic [15:0] pat_of(input logic [22:0] a);
        return a[15:0] ^ 16'hC3A5;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one AR request, wait (bounded) for the handshake and queue the beats it should produce.
    task automatic applyStimulus(input logic id, input logic [22:0] addr, input logic [7:0] len,
                                 input logic [1:0] burst, input logic [2:0] size);
        int    beats;
        bit    legal;
        bit    ok;
        beat_t b;
        beats = int'(len) + 1;
        legal = (burst == 2'b01) && (size == 3'd1) && (beats <= 16);
        ok = 1'b0;
        burst_hs = 0;
        burst_pops = 0;
        max_ahead = 0;
        @(posedge clk); #1;
        arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (arready) begin
                for (int i = 0; i < beats; i++) begin
                    b.data = legal ? pat_of(addr + 23'(i)) : 16'h0000;
                    b.resp = legal ? 2'b00 : 2'b10;
                    b.last = (i == beats - 1);
                    b.id   = id;
                    sb.push_back(b);
                end
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        checkOutput("ar_handshake", 64'(ok), 64'd1);
    endtask

    task automatic waitDrain(input bit toggle, input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (toggle) rready = ((c % 4) == 0) || ((c % 4) == 3);
            if (sb.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        rready = 1'b1;
        checkOutput("drain_done", 64'(done), 64'd1);
    endtask

    // Monitor and read-FIFO model: sample at the falling edge, update FIFO outputs just after the rising edge.
    always begin
        @(negedge clk);
        cyc++;
        mon_do_pop = 1'b0;
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (arvalid && arready) ar_cycle = cyc;
            if (sdram_rd_req) begin
                rd_req_cnt++;
                rd_req_cycle = cyc;
                last_b = sdram_rd_b_addr;
                last_e = sdram_rd_e_addr;
                last_len = rd_burst_len;
                for (int i = 0; i < int'(rd_burst_len); i++) fifo_q.push_back(pat_of(sdram_rd_b_addr + 23'(i)));
            end
            mon_obs.data = rdata;
            mon_obs.resp = rresp;
            mon_obs.last = rlast;
            mon_obs.id   = rid;
            if (stalled) checkOutput("r_stable", 64'({rvalid, mon_obs}), 64'({1'b1, held}));
            if (rvalid && rready) begin
                mon_exp = (sb.size() != 0) ? sb.pop_front() : '1;
                checkOutput("r_beat", 64'(mon_obs), 64'(mon_exp));
                if (burst_hs == 0) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
                burst_hs++;
            end
            stalled = rvalid && !rready;
            held = mon_obs;
            if (rd_fifo_rd_req) begin
                mon_do_pop = 1'b1;
                pops++;
                burst_pops++;
                mon_nxt = (fifo_q.size() != 0) ? fifo_q.pop_front() : 16'hDEAD;
            end
            if (burst_pops - burst_hs > max_ahead) max_ahead = burst_pops - burst_hs;
        end
        @(posedge clk); #1;
        if (mon_do_pop) rd_fifo_rd_data = mon_nxt;
        rd_fifo_num = 10'(fifo_q.size());
    end

    initial begin
        int  base_req;
        int  base_pops;
        bit  seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_r_side", 64'({arready, rid, rdata, rresp, rlast, rvalid, busy}), 64'd0);
        checkOutput("reset_sdram_side", 64'({sdram_rd_req, sdram_rd_b_addr, sdram_rd_e_addr, rd_burst_len, rd_fifo_rd_req}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("[TB] single legal read, RREADY high");
        base_req = rd_req_cnt; base_pops = pops;
        applyStimulus(1'b1, 23'h000100, 8'd15, 2'b01, 3'd1);
        waitDrain(1'b0, 200);
        checkOutput("single_rd_req_count", 64'(rd_req_cnt - base_req), 64'd1);
        checkOutput("single_rd_req_latency", 64'(rd_req_cycle - ar_cycle), 64'd1);
        checkOutput("single_b_addr", 64'(last_b), 64'h000100);
        checkOutput("single_e_addr", 64'(last_e), 64'h000110);
        checkOutput("single_len", 64'(last_len), 64'd16);
        checkOutput("single_pops", 64'(pops - base_pops), 64'd16);
        checkOutput("single_beats", 64'(burst_hs), 64'd16);
        checkOutput("single_no_bubbles", 64'(last_hs_cyc - first_hs_cyc), 64'd15);

        $display("[TB] backpressure, RREADY 1-0-0-1");
        base_pops = pops;
        applyStimulus(1'b0, 23'h002340, 8'd15, 2'b01, 3'd1);
        waitDrain(1'b1, 400);
        checkOutput("bp_pops", 64'(pops - base_pops), 64'd16);
        checkOutput("bp_beats", 64'(burst_hs), 64'd16);
        checkOutput("bp_max_ahead_le2", 64'(max_ahead <= 2), 64'd1);

        $display("[TB] illegal requests");
        base_req = rd_req_cnt; base_pops = pops;
        applyStimulus(1'b1, 23'h000050, 8'd3, 2'b00, 3'd1);
        waitDrain(1'b0, 100);
        checkOutput("fixed_beats", 64'(burst_hs), 64'd4);
        applyStimulus(1'b0, 23'h000060, 8'd16, 2'b01, 3'd1);
        waitDrain(1'b0, 100);
        checkOutput("len16_beats", 64'(burst_hs), 64'd17);
        applyStimulus(1'b1, 23'h000070, 8'd1, 2'b01, 3'd2);
        waitDrain(1'b0, 100);
        checkOutput("size2_beats", 64'(burst_hs), 64'd2);
        checkOutput("illegal_no_rd_req", 64'(rd_req_cnt - base_req), 64'd0);
        checkOutput("illegal_no_pops", 64'(pops - base_pops), 64'd0);

        $display("[TB] end address wrap");
        applyStimulus(1'b0, 23'h7FFFF8, 8'd15, 2'b01, 3'd1);
        waitDrain(1'b0, 200);
        checkOutput("wrap_b_addr", 64'(last_b), 64'h7FFFF8);
        checkOutput("wrap_e_addr", 64'(last_e), 64'h000008);

        $display("[TB] init_end low holds off AR, then a single-beat read");
        @(posedge clk); #1;
        init_end = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        arid = 1'b1; araddr = 23'h001234; arlen = 8'd0; arburst = 2'b01; arsize = 3'd1; arvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("arready_without_init", 64'(arready), 64'd0);
        end
        @(posedge clk); #1;
        init_end = 1'b1;
        applyStimulus(1'b1, 23'h001234, 8'd0, 2'b01, 3'd1);
        waitDrain(1'b0, 100);
        checkOutput("len0_beats", 64'(burst_hs), 64'd1);

        $display("[TB] reset after 5 of 16 beats");
        applyStimulus(1'b0, 23'h004000, 8'd15, 2'b01, 3'd1);
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (burst_hs == 5) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("reached_5_beats", 64'(seen), 64'd1);
        rst_n = 1'b0;
        sb.delete();
        fifo_q.delete();
        @(negedge clk);
        checkOutput("midreset_r_side", 64'({arready, rid, rdata, rresp, rlast, rvalid, busy}), 64'd0);
        checkOutput("midreset_sdram_side", 64'({sdram_rd_req, sdram_rd_b_addr, sdram_rd_e_addr, rd_burst_len, rd_fifo_rd_req}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (arready) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("arready_after_reset", 64'(seen), 64'd1);

        $display("[TB] recovery read after reset");
        applyStimulus(1'b1, 23'h000200, 8'd3, 2'b01, 3'd1);
        waitDrain(1'b0, 100);
        checkOutput("recovery_beats", 64'(burst_hs), 64'd4);
        checkOutput("recovery_e_addr", 64'(last_e), 64'h000204);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
